// File: rtl/axis_pkg.sv
// Shared AXI-Stream constants and pointer-width helper.
package axis_pkg;

    localparam int unsigned AXIS_DATA_WIDTH = 32;
    localparam int unsigned AXIS_FIFO_DEPTH = 16;
    localparam int unsigned AXIS_ID_WIDTH   = 4;
    localparam int unsigned AXIS_DEST_WIDTH = 4;
    localparam int unsigned AXIS_USER_WIDTH = 1;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream bundle. Sideband fields exist only when TSTRB_PRESENT, TKEEP_PRESENT,
// TLAST_PRESENT, TID_PRESENT, TDEST_PRESENT or TUSER_PRESENT is defined.
interface axis_if #(
    parameter int unsigned DATA_WIDTH = axis_pkg::AXIS_DATA_WIDTH
);
    logic                  TVALID;
    logic                  TREADY;
    logic [DATA_WIDTH-1:0] TDATA;
`ifdef TSTRB_PRESENT
    logic [DATA_WIDTH/8-1:0] TSTRB;
`endif
`ifdef TKEEP_PRESENT
    logic [DATA_WIDTH/8-1:0] TKEEP;
`endif
`ifdef TLAST_PRESENT
    logic TLAST;
`endif
`ifdef TID_PRESENT
    logic [axis_pkg::AXIS_ID_WIDTH-1:0] TID;
`endif
`ifdef TDEST_PRESENT
    logic [axis_pkg::AXIS_DEST_WIDTH-1:0] TDEST;
`endif
`ifdef TUSER_PRESENT
    logic [axis_pkg::AXIS_USER_WIDTH-1:0] TUSER;
`endif

    modport s (
`ifdef TSTRB_PRESENT
        input TSTRB,
`endif
`ifdef TKEEP_PRESENT
        input TKEEP,
`endif
`ifdef TLAST_PRESENT
        input TLAST,
`endif
`ifdef TID_PRESENT
        input TID,
`endif
`ifdef TDEST_PRESENT
        input TDEST,
`endif
`ifdef TUSER_PRESENT
        input TUSER,
`endif
        input  TVALID,
        input  TDATA,
        output TREADY
    );

    modport m (
`ifdef TSTRB_PRESENT
        output TSTRB,
`endif
`ifdef TKEEP_PRESENT
        output TKEEP,
`endif
`ifdef TLAST_PRESENT
        output TLAST,
`endif
`ifdef TID_PRESENT
        output TID,
`endif
`ifdef TDEST_PRESENT
        output TDEST,
`endif
`ifdef TUSER_PRESENT
        output TUSER,
`endif
        output TVALID,
        output TDATA,
        input  TREADY
    );

endinterface

// File: rtl/axis_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, contents never reset.
module axis_fifo_mem
    import axis_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [ptr_width(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]            wdata,
    input  logic [ptr_width(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]            rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_fifo.sv
// First-word fall-through AXI-Stream FIFO. Defining AXIS_FIFO_PACKET_MODE_EN (needs
// TLAST_PRESENT) turns it into store-and-forward with cut-through for oversize packets.
module axis_fifo
    import axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int unsigned DEPTH      = AXIS_FIFO_DEPTH
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    axis_if.s                          s_axis,
    axis_if.m                          m_axis,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] pkt_count
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

`ifdef TSTRB_PRESENT
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
`else
    localparam int unsigned STRB_W = 0;
`endif
`ifdef TKEEP_PRESENT
    localparam int unsigned KEEP_W = DATA_WIDTH / 8;
`else
    localparam int unsigned KEEP_W = 0;
`endif
`ifdef TLAST_PRESENT
    localparam int unsigned LAST_W = 1;
`else
    localparam int unsigned LAST_W = 0;
`endif
`ifdef TID_PRESENT
    localparam int unsigned ID_W = AXIS_ID_WIDTH;
`else
    localparam int unsigned ID_W = 0;
`endif
`ifdef TDEST_PRESENT
    localparam int unsigned DEST_W = AXIS_DEST_WIDTH;
`else
    localparam int unsigned DEST_W = 0;
`endif
`ifdef TUSER_PRESENT
    localparam int unsigned USER_W = AXIS_USER_WIDTH;
`else
    localparam int unsigned USER_W = 0;
`endif
    localparam int unsigned ENTRY_W =
        DATA_WIDTH + STRB_W + KEEP_W + LAST_W + ID_W + DEST_W + USER_W;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axis_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               s_ready_q;
    logic               m_valid;
    logic               push, pop;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;

    assign push = s_axis.TVALID && s_ready_q;
    assign pop  = m_valid && m_axis.TREADY;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Ready is taken from the next count so it never depends on m_axis.TREADY combinationally.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            s_ready_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q   <= count_d;
            s_ready_q <= (count_d < FULL);
        end
    end

    // Field order, LSB first: TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER.
    assign wr_entry = {
`ifdef TUSER_PRESENT
        s_axis.TUSER,
`endif
`ifdef TDEST_PRESENT
        s_axis.TDEST,
`endif
`ifdef TID_PRESENT
        s_axis.TID,
`endif
`ifdef TLAST_PRESENT
        s_axis.TLAST,
`endif
`ifdef TKEEP_PRESENT
        s_axis.TKEEP,
`endif
`ifdef TSTRB_PRESENT
        s_axis.TSTRB,
`endif
        s_axis.TDATA
    };

    axis_fifo_mem #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (ACLK),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    assign m_axis.TDATA = rd_entry[DATA_WIDTH-1:0];
`ifdef TSTRB_PRESENT
    assign m_axis.TSTRB = rd_entry[DATA_WIDTH +: STRB_W];
`endif
`ifdef TKEEP_PRESENT
    assign m_axis.TKEEP = rd_entry[DATA_WIDTH + STRB_W +: KEEP_W];
`endif
`ifdef TLAST_PRESENT
    assign m_axis.TLAST = rd_entry[DATA_WIDTH + STRB_W + KEEP_W];
`endif
`ifdef TID_PRESENT
    assign m_axis.TID = rd_entry[DATA_WIDTH + STRB_W + KEEP_W + LAST_W +: ID_W];
`endif
`ifdef TDEST_PRESENT
    assign m_axis.TDEST = rd_entry[DATA_WIDTH + STRB_W + KEEP_W + LAST_W + ID_W +: DEST_W];
`endif
`ifdef TUSER_PRESENT
    assign m_axis.TUSER =
        rd_entry[DATA_WIDTH + STRB_W + KEEP_W + LAST_W + ID_W + DEST_W +: USER_W];
`endif

`ifdef AXIS_FIFO_PACKET_MODE_EN
`ifdef TLAST_PRESENT
    logic [CNT_W-1:0] pkt_q;
    logic             cut_q;
    logic             push_last, pop_last;

    assign push_last = push && s_axis.TLAST;
    assign pop_last  = pop && rd_entry[DATA_WIDTH + STRB_W + KEEP_W];

    // A full FIFO with no complete packet holds one oversize packet: stream it out.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            pkt_q <= '0;
            cut_q <= 1'b0;
        end else begin
            if (push_last && !pop_last) begin
                pkt_q <= pkt_q + CNT_W'(1);
            end else if (pop_last && !push_last) begin
                pkt_q <= pkt_q - CNT_W'(1);
            end
            if (pop_last) begin
                cut_q <= 1'b0;
            end else if (count_q == FULL && pkt_q == '0) begin
                cut_q <= 1'b1;
            end
        end
    end

    assign m_valid   = (count_q != '0) && ((pkt_q != '0) || cut_q || (count_q == FULL));
    assign pkt_count = pkt_q;
`else
    if (1) begin : g_no_tlast
        $error("axis_fifo: AXIS_FIFO_PACKET_MODE_EN requires TLAST_PRESENT");
    end
    assign m_valid   = (count_q != '0);
    assign pkt_count = '0;
`endif
`else
    assign m_valid   = (count_q != '0);
    assign pkt_count = '0;
`endif

    assign m_axis.TVALID = m_valid;
    assign s_axis.TREADY = s_ready_q;
    assign count         = count_q;

endmodule
